// File: rtl/bus_pkg.sv
// bus_pkg: shared constants and types for the CPU bus decoder.
//   - Address map bases/limits (boot overlay window, I/O, ROM); every window is
//     a naturally aligned power-of-two block so membership is a mask compare.
//   - FSM state encodings (plain localparams for legacy tools).
//   - Default watchdog limit.
package bus_pkg;

    localparam logic [31:0] OVL_BASE  = 32'h0000_0000;
    localparam logic [31:0] OVL_LIMIT = 32'h000F_FFFF;
    localparam logic [31:0] IO_BASE   = 32'hFFE0_0000;
    localparam logic [31:0] IO_LIMIT  = 32'hFFEF_FFFF;
    localparam logic [31:0] ROM_BASE  = 32'hFFF0_0000;
    localparam logic [31:0] ROM_LIMIT = 32'hFFFF_FFFF;

    localparam logic [2:0] FC_CPU_SPACE = 3'b111;

    localparam int TIMEOUT_CYCLES_DEFAULT = 256;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_ACTIVE = 3'd2;
    localparam logic [2:0] ST_FAULT  = 3'd3;
    localparam logic [2:0] ST_ENDC   = 3'd4;

    typedef enum logic [1:0] {
        REG_NONE,
        REG_RAM,
        REG_ROM,
        REG_IO
    } region_t;

    // True when addr lies in the aligned window [base, limit].
    function automatic logic in_region(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input logic [31:0] limit);
        return (addr & ~(limit - base)) == base;
    endfunction

endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchronizer for a single asynchronous level.
// Ports:
//   clk_i  - destination clock
//   rst_i  - synchronous active-high reset; both flops reset to 1
//   d_i    - asynchronous input
//   q_o    - synchronized output (second flop)
module sync2 (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/bus_decoder.sv
// bus_decoder: address decoder and bus watchdog for the CPU bus.
// Decodes each CPU cycle into one of the RAM / ROM / I/O selects, raises BERR
// for unmapped addresses or when no slave terminates within TIMEOUT_CYCLES,
// and implements the boot overlay that maps ROM over low RAM for reads.
// Ports:
//   CLK      - 50 MHz clock (only clock)
//   RST      - synchronous active-high reset
//   cpu_nAS  - CPU address strobe, asynchronous, active-low
//   RnW      - 1 = read
//   FC       - CPU function code
//   ADDR     - CPU address
//   DSACK_IN - OR of slave terminations, active-high
//   nRAMSEL  - DRAM select, active-low
//   nROMSEL  - boot ROM select, active-low
//   nIOSEL   - I/O select, active-low
//   BERR     - bus error, active-high
module bus_decoder
    import bus_pkg::*;
#(
    parameter int RAM_SIZE_LOG2  = 28,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        cpu_nAS,
    input  logic        RnW,
    input  logic [2:0]  FC,
    input  logic [31:0] ADDR,
    input  logic [1:0]  DSACK_IN,
    output logic        nRAMSEL,
    output logic        nROMSEL,
    output logic        nIOSEL,
    output logic        BERR
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX  = '1;

    logic nas_s;

    sync2 u_sync (
        .clk_i (CLK),
        .rst_i (RST),
        .d_i   (cpu_nAS),
        .q_o   (nas_s)
    );

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovl_q, ovl_d;
    logic          armed_q, armed_d;
    logic [1:0]    prime_q, prime_d;
    logic          acked_q, acked_d;
    logic          nram_q, nram_d;
    logic          nrom_q, nrom_d;
    logic          nio_q, nio_d;
    logic          berr_q, berr_d;

    // Address decode, only consumed in DECODE.
    region_t region;
    logic    unmapped;
    logic    rom_real;

    always_comb begin
        region   = REG_NONE;
        unmapped = 1'b0;
        rom_real = 1'b0;
        if (FC == FC_CPU_SPACE) begin
            region = REG_NONE;
        end else if (ovl_q && RnW && in_region(ADDR, OVL_BASE, OVL_LIMIT)) begin
            region = REG_ROM;
        end else if ((ADDR >> RAM_SIZE_LOG2) == 32'd0) begin
            region = REG_RAM;
        end else if (in_region(ADDR, IO_BASE, IO_LIMIT)) begin
            region = REG_IO;
        end else if (in_region(ADDR, ROM_BASE, ROM_LIMIT)) begin
            region   = REG_ROM;
            rom_real = 1'b1;
        end else begin
            unmapped = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ovl_d   = ovl_q;
        armed_d = armed_q;
        acked_d = acked_q;
        nram_d  = nram_q;
        nrom_d  = nrom_q;
        nio_d   = nio_q;
        berr_d  = berr_q;

        // After reset the synchronizer still holds its forced 1s for two
        // edges; nAS_s only reflects the real strobe once both flops have
        // shifted in a sample. Arming on those forced 1s would let a strobe
        // that stayed low through reset be decoded, so hold off until primed.
        prime_d = (prime_q == 2'd2) ? 2'd2 : prime_q + 2'd1;
        if (nas_s && prime_q == 2'd2) begin
            armed_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (!nas_s && armed_q) begin
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                cnt_d   = '0;
                acked_d = 1'b0;
                if (unmapped) begin
                    state_d = ST_FAULT;
                    berr_d  = 1'b1;
                end else begin
                    state_d = ST_ACTIVE;
                    nram_d  = (region != REG_RAM);
                    nrom_d  = (region != REG_ROM);
                    nio_d   = (region != REG_IO);
                    if (rom_real) begin
                        ovl_d = 1'b0;
                    end
                end
            end
            ST_ACTIVE: begin
                // Strobe negation wins over a same-cycle timeout.
                if (nas_s) begin
                    state_d = ST_ENDC;
                    nram_d  = 1'b1;
                    nrom_d  = 1'b1;
                    nio_d   = 1'b1;
                end else if (!acked_q && DSACK_IN == 2'b00 && cnt_q == CNT_LAST) begin
                    state_d = ST_FAULT;
                    nram_d  = 1'b1;
                    nrom_d  = 1'b1;
                    nio_d   = 1'b1;
                    berr_d  = 1'b1;
                end else if (DSACK_IN != 2'b00) begin
                    // Once a slave has terminated, the watchdog stays frozen
                    // for the rest of this cycle.
                    acked_d = 1'b1;
                end else if (!acked_q && cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_ENDC: begin
                state_d = ST_IDLE;
                nram_d  = 1'b1;
                nrom_d  = 1'b1;
                nio_d   = 1'b1;
            end
            ST_FAULT: begin
                if (nas_s) begin
                    state_d = ST_IDLE;
                    berr_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                nram_d  = 1'b1;
                nrom_d  = 1'b1;
                nio_d   = 1'b1;
                berr_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ovl_q   <= 1'b1;
            armed_q <= 1'b0;
            prime_q <= 2'd0;
            acked_q <= 1'b0;
            nram_q  <= 1'b1;
            nrom_q  <= 1'b1;
            nio_q   <= 1'b1;
            berr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ovl_q   <= ovl_d;
            armed_q <= armed_d;
            prime_q <= prime_d;
            acked_q <= acked_d;
            nram_q  <= nram_d;
            nrom_q  <= nrom_d;
            nio_q   <= nio_d;
            berr_q  <= berr_d;
        end
    end

    assign nRAMSEL = nram_q;
    assign nROMSEL = nrom_q;
    assign nIOSEL  = nio_q;
    assign BERR    = berr_q;

endmodule

// File: doc/bus_decoder.md
BUS_DECODER -- requirements
Module: bus_decoder

Interface
REQ-001 Parameter RAM_SIZE_LOG2, default 28; log2 of installed DRAM bytes; legal range 20..28.
REQ-002 Parameter TIMEOUT_CYCLES, default 256; bus watchdog limit in CLK cycles; legal range 4..4096.
REQ-003 CLK  in  1  50 MHz DRAM-domain clock; the only clock.
REQ-004 RST  in  1  reset, synchronous, active-high.
REQ-005 cpu_nAS  in  1  CPU address strobe, asynchronous to CLK.
REQ-006 RnW  in  1  CPU read/write; 1 = read.
REQ-007 FC  in  3  CPU function code.
REQ-008 ADDR  in  32  CPU address bus.
REQ-009 DSACK_IN  in  2  OR of all slave DSACK terminations; active-high.
REQ-010 nRAMSEL  out  1  DRAM select to the DRAM controller; active-low.
REQ-011 nROMSEL  out  1  boot ROM select; active-low.
REQ-012 nIOSEL  out  1  I/O region select; active-low.
REQ-013 BERR  out  1  bus error; active-high; drives an open-drain inverter.

Function
REQ-014 cpu_nAS SHALL pass through a two-flop synchronizer before use; the second flop output is nAS_s.
REQ-015 Map: RAM at 0x0000_0000 up to 2^RAM_SIZE_LOG2-1; I/O at 0xFFE0_0000-0xFFEF_FFFF; ROM at 0xFFF0_0000-0xFFFF_FFFF; all other addresses are unmapped.
REQ-016 FC=3'b111 (CPU space) SHALL decode as no select and SHALL NOT be treated as unmapped; termination comes from elsewhere and only the watchdog applies.
REQ-017 Boot overlay flag OVL SHALL be set by reset; while OVL=1, reads in 0x0000_0000-0x000F_FFFF SHALL select ROM instead of RAM; writes there SHALL select RAM.
REQ-018 OVL SHALL clear at the DECODE cycle of the first ROM select made at ROM's real address; OVL SHALL never set again except by reset.
REQ-019 The state machine SHALL have states IDLE, DECODE, ACTIVE, FAULT and ENDC.
REQ-020 IDLE->DECODE SHALL occur when nAS_s=0 and armed=1; armed SHALL be cleared by reset and set on any cycle with nAS_s=1.
REQ-021 In DECODE, at most one select SHALL be registered from ADDR, FC, RnW and OVL.
REQ-022 In DECODE, a mapped address or CPU space SHALL go to ACTIVE with the watchdog counter cleared to 0; an unmapped address SHALL go to FAULT with BERR=1 from the next cycle.
REQ-023 Select latency: the select SHALL assert on the second CLK edge after nAS_s first reads 0.
REQ-024 In ACTIVE, the counter SHALL increment every cycle while DSACK_IN=2'b00 and SHALL freeze once DSACK_IN is nonzero.
REQ-025 When the counter reaches TIMEOUT_CYCLES-1 with DSACK_IN=0, the block SHALL go to FAULT, deassert all selects and set BERR=1.
REQ-026 If nAS_s=1 in ACTIVE, the block SHALL go to ENDC; this takes priority over a same-cycle timeout.
REQ-027 In ENDC, all selects SHALL deassert and the block SHALL return to IDLE on the next cycle.
REQ-028 In FAULT, BERR SHALL stay at 1 until nAS_s=1; the block SHALL then clear BERR and go to IDLE in the same edge.
REQ-029 The counter SHALL be wide enough for TIMEOUT_CYCLES and SHALL saturate without wrap.

Reset
REQ-030 On RST=1 at a CLK edge: state=IDLE; synchronizer flops=1; nRAMSEL=nROMSEL=nIOSEL=1; BERR=0; counter=0; OVL=1; armed=0.
REQ-031 Reset mid-cycle SHALL drop selects and BERR at that edge; a strobe already low SHALL NOT be decoded until it is seen high.

Structure
REQ-032 Package bus_pkg SHALL hold the region base/limit constants, the state enumeration and the default TIMEOUT_CYCLES.
REQ-033 A sub-module sync2 (two-flop synchronizer, reset value 1) SHALL be used for cpu_nAS.

Verification
REQ-034 Read at ADDR=0x0000_1000 after reset (OVL=1) -> nROMSEL=0 two edges after nAS_s=0; nRAMSEL=1.
REQ-035 Read at 0xFFF0_0004, then read at 0x0000_1000 -> first cycle nROMSEL=0 and OVL cleared; second cycle nRAMSEL=0.
REQ-036 Write at 0x0000_1000 with OVL=1 -> nRAMSEL=0; nROMSEL=1.
REQ-037 Access at 0x8000_0000 (unmapped) -> BERR=1 one cycle after DECODE; all selects=1; BERR=0 the edge after nAS_s=1.
REQ-038 RAM read with DSACK_IN held 0, TIMEOUT_CYCLES=16 -> BERR=1 after 16 ACTIVE cycles; repeat with DSACK_IN=2'b11 at cycle 5 -> no BERR; ENDC follows nAS negation.
REQ-039 RST=1 during ACTIVE with cpu_nAS held low -> selects=1 and BERR=0 at the reset edge; no DECODE until cpu_nAS goes high then low.
